// File: rtl/cache_pkg.sv
// Default geometry, derived widths, entry field positions and request encodings for the N-way cache.
package cache_pkg;

    localparam int DEF_WORD_SIZE       = 32;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_NUM_BLOCKS      = 64;
    localparam int DEF_NUM_WAYS        = 8;
    localparam int DEF_NUM_SETS        = DEF_NUM_BLOCKS / DEF_NUM_WAYS;
    localparam int DEF_INDEX_WIDTH     = $clog2(DEF_NUM_SETS);
    localparam int DEF_OFFSET_WIDTH    = $clog2(DEF_WORDS_PER_BLOCK);
    localparam int DEF_TAG_WIDTH       = 32 - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH;

    // Entry layout: {block, tag, dirty, valid}
    localparam int VALID_BIT = 0;
    localparam int DIRTY_BIT = 1;
    localparam int TAG_LSB   = 2;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    function automatic int way_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_replacement.sv
// Per-set replacement state and victim choice (lowest invalid way first).
// CACHE_TRUE_LRU_EN selects true LRU ages; otherwise a round-robin pointer advanced on refill.
module cache_replacement
    import cache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int NUM_WAYS    = DEF_NUM_WAYS,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    localparam int WAY_W      = way_width(NUM_WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [NUM_WAYS-1:0]    set_valid,
    input  logic                   touch,
    input  logic                   refill,
    input  logic [WAY_W-1:0]       touch_way,
    output logic [WAY_W-1:0]       victim
);

    logic [WAY_W-1:0] choice;

`ifdef CACHE_TRUE_LRU_EN
    logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
    logic             unused_refill;
    assign unused_refill = refill;

    // Touched way goes to age 0; younger valid ways age by one. A fill into an
    // invalid way ages every valid way, so valid ages stay a strict ranking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age[s][w] <= '0;
        end else if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age[index][w] <= '0;
                else if (set_valid[w] && age[index][w] != '1 &&
                         (!set_valid[touch_way] || age[index][w] < age[index][touch_way]))
                    age[index][w] <= age[index][w] + 1'b1;
            end
        end
    end

    always_comb begin
        choice = '0;
        for (int w = 1; w < NUM_WAYS; w++)
            if (age[index][w] > age[index][choice])
                choice = WAY_W'(w);
    end
`else
    logic [WAY_W-1:0] ptr [NUM_SETS];
    logic             unused_touch;
    assign unused_touch = touch ^ (^touch_way);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++)
                ptr[s] <= '0;
        end else if (refill) begin
            ptr[index] <= ptr[index] + 1'b1;
        end
    end

    assign choice = ptr[index];
`endif

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = choice;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !set_valid[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nway_cache_memory.sv
// N-way set-associative write-back cache array: tag compare, word access, refill and victim write-back.
// Replacement policy: round-robin by default, true LRU when CACHE_TRUE_LRU_EN is defined.
module nway_cache_memory
    import cache_pkg::*;
#(
    parameter int WORD_SIZE       = DEF_WORD_SIZE,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int NUM_BLOCKS      = DEF_NUM_BLOCKS,
    parameter int NUM_WAYS        = DEF_NUM_WAYS,
    localparam int BLOCK_SIZE     = WORDS_PER_BLOCK * WORD_SIZE,
    localparam int NUM_SETS       = NUM_BLOCKS / NUM_WAYS,
    localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
    localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] blk_offset,
    input  logic                    req_type,
    input  logic                    read_en_cache,
    input  logic                    write_en_cache,
    input  logic                    read_en_mem,
    input  logic                    write_en_mem,
    input  logic [BLOCK_SIZE-1:0]   data_in_mem,
    input  logic [WORD_SIZE-1:0]    data_in,
    output logic [BLOCK_SIZE-1:0]   dirty_block_out,
    output logic                    hit,
    output logic [WORD_SIZE-1:0]    data_out,
    output logic                    dirty_bit
);

    localparam int WAY_W   = way_width(NUM_WAYS);
    localparam int BLK_LSB = TAG_LSB + TAG_WIDTH;
    localparam int ENTRY_W = BLK_LSB + BLOCK_SIZE;

    logic [ENTRY_W-1:0]    cache [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   hit_vec, valid_vec;
    logic [WAY_W-1:0]      hit_way, victim, accessed_way;
    logic [ENTRY_W-1:0]    hit_entry, victim_entry;
    logic [BLOCK_SIZE-1:0] hit_block;
    logic                  rd_hit, wr_hit, refill;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign valid_vec[w] = cache[index][w][VALID_BIT];
        assign hit_vec[w]   = valid_vec[w] && (cache[index][w][BLK_LSB-1:TAG_LSB] == tag);
    end

    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (hit_vec[w]) hit_way = WAY_W'(w);
    end

    assign hit          = |hit_vec;
    assign accessed_way = hit ? hit_way : victim;
    assign hit_entry    = cache[index][hit_way];
    assign hit_block    = hit_entry[ENTRY_W-1:BLK_LSB];
    assign victim_entry = cache[index][victim];
    assign dirty_bit    = victim_entry[VALID_BIT] && victim_entry[DIRTY_BIT];

    assign refill = read_en_mem && write_en_cache;
    assign rd_hit = read_en_cache && (req_type == REQ_READ) && hit;
    assign wr_hit = write_en_cache && (req_type == REQ_WRITE) && hit && !read_en_mem;

    cache_replacement #(
        .NUM_SETS    (NUM_SETS),
        .NUM_WAYS    (NUM_WAYS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_repl (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .set_valid (valid_vec),
        .touch     (rd_hit || wr_hit || refill),
        .refill    (refill),
        .touch_way (accessed_way),
        .victim    (victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out        <= '0;
            dirty_block_out <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    cache[s][w][VALID_BIT] <= 1'b0;
                    cache[s][w][DIRTY_BIT] <= 1'b0;
                end
            end
        end else begin
            if (rd_hit)
                data_out <= hit_block[int'(blk_offset)*WORD_SIZE +: WORD_SIZE];
            if (write_en_mem)
                dirty_block_out <= victim_entry[ENTRY_W-1:BLK_LSB];
            // Refill wins over a word write issued in the same cycle.
            if (refill) begin
                cache[index][accessed_way] <= {data_in_mem, tag, 1'b0, 1'b1};
            end else if (wr_hit) begin
                cache[index][hit_way][BLK_LSB + int'(blk_offset)*WORD_SIZE +: WORD_SIZE] <= data_in;
                cache[index][hit_way][DIRTY_BIT] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nway_cache_memory.sv
// Directed bench for nway_cache_memory: reset, refill, read/write hits, victim choice, write-back, reset abort.
module tb_nway_cache_memory;

    logic         clk = 1'b0;
    logic         rst;
    logic [26:0]  tag;
    logic [2:0]   index;
    logic [1:0]   blk_offset;
    logic         req_type;
    logic         read_en_cache, write_en_cache, read_en_mem, write_en_mem;
    logic [127:0] data_in_mem;
    logic [31:0]  data_in;
    logic [127:0] dirty_block_out;
    logic         hit;
    logic [31:0]  data_out;
    logic         dirty_bit;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] D0 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D1 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    localparam logic [127:0] D4 = 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321;
    localparam logic [127:0] D5 = 128'h55550003_55550002_55550001_55550000;

    nway_cache_memory dut (
        .clk             (clk),
        .rst             (rst),
        .tag             (tag),
        .index           (index),
        .blk_offset      (blk_offset),
        .req_type        (req_type),
        .read_en_cache   (read_en_cache),
        .write_en_cache  (write_en_cache),
        .read_en_mem     (read_en_mem),
        .write_en_mem    (write_en_mem),
        .data_in_mem     (data_in_mem),
        .data_in         (data_in),
        .dirty_block_out (dirty_block_out),
        .hit             (hit),
        .data_out        (data_out),
        .dirty_bit       (dirty_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic req(input logic [26:0] t, input logic [2:0] idx, input logic [1:0] off, input logic rt);
        tag = t; index = idx; blk_offset = off; req_type = rt;
        #1;
    endtask

    task automatic pulse(input logic rc, input logic wc, input logic rm, input logic wm);
        read_en_cache = rc; write_en_cache = wc; read_en_mem = rm; write_en_mem = wm;
        @(posedge clk); #1;
        read_en_cache = 0; write_en_cache = 0; read_en_mem = 0; write_en_mem = 0;
        #1;
    endtask

    task automatic refill_blk(input logic [26:0] t, input logic [127:0] d);
        req(t, 3'd0, 2'd0, 1'b0);
        data_in_mem = d;
        pulse(0, 1, 1, 0);
    endtask

    task automatic read_word(input logic [26:0] t, input logic [2:0] idx, input logic [1:0] off);
        req(t, idx, off, 1'b0);
        pulse(1, 0, 0, 0);
    endtask

    initial begin
        rst = 1; tag = '0; index = '0; blk_offset = '0; req_type = 0;
        read_en_cache = 0; write_en_cache = 0; read_en_mem = 0; write_en_mem = 0;
        data_in_mem = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1: reset state
        req(27'h0DEF01, 3'd0, 2'd0, 1'b0);
        chk("rst_hit", 128'(hit), 128'(1'b0));
        chk("rst_dirty_bit", 128'(dirty_bit), 128'(1'b0));
        pulse(1, 0, 0, 0);
        chk("rst_data_out", 128'(data_out), 128'h0);
        chk("rst_dirty_block_out", dirty_block_out, 128'h0);

        // 2: refill and read words
        refill_blk(27'h0DEF01, D0);
        chk("refill_hit", 128'(hit), 128'(1'b1));
        read_word(27'h0DEF01, 3'd0, 2'd0);
        chk("read_off0", 128'(data_out), 128'h77778888);
        read_word(27'h0DEF01, 3'd0, 2'd3);
        chk("read_off3", 128'(data_out), 128'h11112222);
        req(27'h0DEF01, 3'd1, 2'd0, 1'b0);
        chk("other_set_miss", 128'(hit), 128'(1'b0));
        read_word(27'h000001, 3'd0, 2'd0);
        chk("miss_read_hit", 128'(hit), 128'(1'b0));
        chk("miss_read_holds", 128'(data_out), 128'h11112222);

        // 3: write hit
        refill_blk(27'h0FF002, D1);
        req(27'h0FF002, 3'd0, 2'd1, 1'b1);
        data_in = 32'h88889999;
        chk("wr_hit_pre", 128'(hit), 128'(1'b1));
        pulse(0, 1, 0, 0);
        read_word(27'h0FF002, 3'd0, 2'd1);
        chk("wr_readback", 128'(data_out), 128'h88889999);
        read_word(27'h0FF002, 3'd0, 2'd0);
        chk("wr_neighbour", 128'(data_out), 128'hAAAA0000);

        // 4: fill set 0, touch ways 0..7 in order, way 0 must be the victim
        for (int w = 2; w < 8; w++) refill_blk(27'h100 + 27'(w), {4{32'(w)}});
        read_word(27'h0DEF01, 3'd0, 2'd0);
        read_word(27'h0FF002, 3'd0, 2'd0);
        for (int w = 2; w < 8; w++) read_word(27'h100 + 27'(w), 3'd0, 2'd0);
        chk("touch_way7", 128'(data_out), 128'h7);
        req(27'h11AA35, 3'd0, 2'd0, 1'b0);
        chk("full_miss_hit", 128'(hit), 128'(1'b0));
        chk("full_miss_dirty", 128'(dirty_bit), 128'(1'b0));
        pulse(0, 0, 0, 1);
        chk("victim_way0_block", dirty_block_out, D0);
        refill_blk(27'h11AA35, D4);
        read_word(27'h11AA35, 3'd0, 2'd0);
        chk("lru_refill_off0", 128'(data_out), 128'h87654321);
        req(27'h0DEF01, 3'd0, 2'd0, 1'b0);
        chk("evicted_miss", 128'(hit), 128'(1'b0));

        // 5: dirty victim write-back
        req(27'h012345, 3'd0, 2'd0, 1'b0);
        chk("dirty_victim_bit", 128'(dirty_bit), 128'(1'b1));
        pulse(0, 0, 0, 1);
        chk("writeback_block", dirty_block_out, 128'hAAAA0003_AAAA0002_88889999_AAAA0000);
        req(27'h0FF002, 3'd0, 2'd0, 1'b0);
        chk("writeback_no_change", 128'(hit), 128'(1'b1));
        refill_blk(27'h012345, D5);
        chk("wb_refill_hit", 128'(hit), 128'(1'b1));
        read_word(27'h012345, 3'd0, 2'd2);
        chk("wb_refill_off2", 128'(data_out), 128'h55550002);
        req(27'h0FF002, 3'd0, 2'd0, 1'b0);
        chk("dirty_line_evicted", 128'(hit), 128'(1'b0));

        // 6: reset between miss and refill
        req(27'h007777, 3'd0, 2'd0, 1'b0);
        data_in_mem = D4;
        rst = 1; read_en_mem = 1; write_en_cache = 1;
        @(posedge clk); #1;
        rst = 0; read_en_mem = 0; write_en_cache = 0;
        #1;
        chk("rst_refill_ignored", 128'(hit), 128'(1'b0));
        req(27'h012345, 3'd0, 2'd0, 1'b0);
        chk("rst_invalidates", 128'(hit), 128'(1'b0));
        chk("rst2_dirty_bit", 128'(dirty_bit), 128'(1'b0));
        chk("rst2_data_out", 128'(data_out), 128'h0);
        chk("rst2_dirty_block_out", dirty_block_out, 128'h0);
        refill_blk(27'h007777, D5);
        read_word(27'h007777, 3'd0, 2'd3);
        chk("post_rst_refill", 128'(data_out), 128'h55550003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
